latch_gate_seq: RTL and testbench
=================================

# latch_gate_seq

Sequencer that drives the control pins (I, GE, SET, RST) of a bank of WIDTH gated set/reset latch cells sitting directly downstream. It accepts write, clear and preset commands over a REQ/ACK handshake. It guarantees clean data setup before the gate opens and data hold after it closes. It also guarantees a full-width SET/RST pulse with a recovery cycle, so the latch bank's setup/hold, recovery and width checks never fire.

## Interface
- WIDTH, 8, latch bank data width
- GATE_CYCLES, 2, cycles LGE is held high per write (≥1)
- PULSE_CYCLES, 1, cycles LSET/LRST is held high per preset/clear (≥1)

- CLK  in  1  clock, rising edge
- RST  in  1  reset, asynchronous, active-low
- REQ  in  1  command request
- CMD  in  2  00 write, 01 clear, 10 preset, 11 illegal
- D  in  WIDTH  write data, sampled on accept
- ACK  out  1  ready to accept
- LI  out  WIDTH  latch data (to I)
- LGE  out  1  latch gate enable (to GE)
- LSET  out  1  latch preset (to SET)
- LRST  out  1  latch clear (to RST)
- DONE  out  1  one-cycle completion pulse
- ERR  out  1  one-cycle illegal-command pulse

## Operation
- All outputs are registered. The clock is CLK. The reset is RST: asynchronous, active-low, fixed.
- Reset values, applied immediately while RST=0:
  - State INIT.
  - ACK=0, LI=0, LGE=0, LSET=0, DONE=0, ERR=0.
  - LRST=1, so the latch bank is held cleared throughout reset.
- States: INIT, IDLE, SETUP, GATE, HOLD, PULSE, RECOVER.
- INIT: the first rising edge after RST releases drives LRST=0 and moves to IDLE.
- IDLE:
  - ACK=1.
  - A command is accepted on a rising edge with REQ=1 and ACK=1. ACK drops in the next cycle.
- Write (CMD=00):
  - D is captured into LI on the accept edge.
  - SETUP: 1 cycle with LGE=0.
  - GATE: GATE_CYCLES cycles with LGE=1.
  - HOLD: 1 cycle with LGE=0 and DONE=1.
  - Then IDLE.
- Clear (01) / preset (10):
  - PULSE: PULSE_CYCLES cycles with LRST=1 (clear) or LSET=1 (preset).
  - RECOVER: 1 cycle with LSET=LRST=0 and DONE=1.
  - Then IDLE.
- Illegal (11):
  - Accepted. ERR=1 for the following cycle.
  - State stays IDLE with ACK=1. No latch pin changes. No DONE.
- LI changes only on the write-accept edge. It holds its value at all other times, including across clear/preset. It is never 'x' after reset.
- LSET and LRST are never high together. LGE is never high while LSET or LRST is high.
- GATE and PULSE durations use a down-counter of width clog2(max(GATE_CYCLES, PULSE_CYCLES)+1). It loads the duration on state entry and exits when the count reaches 1.
- REQ while ACK=0 is ignored; CMD and D are don't-care in that case. Requests are not queued.
- Reset mid-operation: every output returns to its reset value asynchronously. The in-flight command is dropped. No DONE or ERR is emitted.

## Timing
- Accept edge T. Cycle k means the cycle after edge T+k.
- Write:
  - LI valid from cycle 0.
  - LGE=1 in cycles 1..GATE_CYCLES.
  - DONE in cycle GATE_CYCLES+1.
  - ACK=1 again in cycle GATE_CYCLES+2.
  - Occupancy is GATE_CYCLES+2 cycles.
- Clear/preset:
  - Pulse in cycles 0..PULSE_CYCLES-1.
  - DONE in cycle PULSE_CYCLES.
  - ACK=1 in cycle PULSE_CYCLES+1.
- Illegal: ERR in cycle 0. ACK remains 1, so a back-to-back accept is allowed at edge T+1.
- Minimum spacing between legal accepts is occupancy+1 edges; there is no overlap.
- LI is stable for 1 cycle before LGE rises and for 1 cycle after LGE falls.

## Test plan
- Reset release, WIDTH=8, GATE_CYCLES=2:
  - Stimulus: hold RST=0 for 3 cycles, then release.
  - Response: LRST=1 and ACK=0 during reset; LRST=0 and ACK=1 after the first edge; LI=0x00.
- Write 0xA5 with GATE_CYCLES=2:
  - Response: LI=0xA5 in cycle 0; LGE=1 exactly in cycles 1–2; DONE in cycle 3 only; ACK back in cycle 4.
- Clear, then preset, with PULSE_CYCLES=3:
  - Response: LRST=1 for cycles 0–2 and DONE in cycle 3.
  - Then LSET=1 for 3 cycles with LRST=0 throughout; LI unchanged at 0xA5.
- Illegal CMD=11 then immediate write 0x3C:
  - Response: ERR=1 for one cycle with no DONE.
  - The write is accepted on the next edge and completes normally.
- REQ held high continuously with alternating write commands:
  - Response: each is accepted only when ACK=1; there is exactly one DONE per accept; LGE and LSET/LRST are never concurrent.
- RST asserted during the GATE state:
  - Response: LGE=0 and LRST=1 immediately; no DONE.
  - After release, INIT→IDLE and a new write completes correctly.

Source files
------------

// File: rtl/latch_gate_seq_if.sv
// Command and latch-pin bundle for latch_gate_seq; master issues commands, slave sequences the pins.
// Data width follows the latch bank; every slave output is registered.
interface latch_gate_seq_if #(
   parameter int WIDTH = 8
);
   logic             req;
   logic [1:0]       cmd;
   logic [WIDTH-1:0] d;
   logic             ack;
   logic [WIDTH-1:0] li;
   logic             lge;
   logic             lset;
   logic             lrst;
   logic             done;
   logic             err;

   modport master (
      output req, cmd, d,
      input  ack, li, lge, lset, lrst, done, err
   );

   modport slave (
      input  req, cmd, d,
      output ack, li, lge, lset, lrst, done, err
   );
endinterface

// File: rtl/latch_gate_seq.sv
// Sequences I/GE/SET/RST of a gated latch bank; write takes GATE_CYCLES+2, clear/preset PULSE_CYCLES+1.
// Backpressure: ack is high only in IDLE; requests seen while ack=0 are dropped, never queued.
module latch_gate_seq #(
   parameter int WIDTH        = 8,
   parameter int GATE_CYCLES  = 2,
   parameter int PULSE_CYCLES = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   latch_gate_seq_if.slave  bus
);
   localparam int MAX_CYC = (GATE_CYCLES > PULSE_CYCLES) ? GATE_CYCLES : PULSE_CYCLES;
   localparam int CW      = $clog2(MAX_CYC + 1);
   localparam logic [CW-1:0] GATE_LD  = CW'(GATE_CYCLES);
   localparam logic [CW-1:0] PULSE_LD = CW'(PULSE_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(1);

   typedef enum logic [2:0] {
      INIT, IDLE, SETUP, GATE, HOLD, PULSE, RECOVER
   } state_t;

   state_t           state;
   logic [CW-1:0]    cnt;
   logic             ack_q;
   logic [WIDTH-1:0] li_q;
   logic             lge_q;
   logic             lset_q;
   logic             lrst_q;
   logic             done_q;
   logic             err_q;

   // Latch bank is held cleared (lrst=1) for the whole reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= INIT;
         cnt    <= '0;
         ack_q  <= 1'b0;
         li_q   <= '0;
         lge_q  <= 1'b0;
         lset_q <= 1'b0;
         lrst_q <= 1'b1;
         done_q <= 1'b0;
         err_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         err_q  <= 1'b0;
         case (state)
            INIT: begin
               lrst_q <= 1'b0;
               ack_q  <= 1'b1;
               state  <= IDLE;
            end
            IDLE: begin
               if (bus.req && ack_q) begin
                  case (bus.cmd)
                     2'b00: begin
                        li_q  <= bus.d;
                        ack_q <= 1'b0;
                        state <= SETUP;
                     end
                     2'b01: begin
                        lrst_q <= 1'b1;
                        cnt    <= PULSE_LD;
                        ack_q  <= 1'b0;
                        state  <= PULSE;
                     end
                     2'b10: begin
                        lset_q <= 1'b1;
                        cnt    <= PULSE_LD;
                        ack_q  <= 1'b0;
                        state  <= PULSE;
                     end
                     default: err_q <= 1'b1;
                  endcase
               end
            end
            SETUP: begin
               lge_q <= 1'b1;
               cnt   <= GATE_LD;
               state <= GATE;
            end
            GATE: begin
               if (cnt == CNT_LAST) begin
                  lge_q  <= 1'b0;
                  done_q <= 1'b1;
                  state  <= HOLD;
               end else begin
                  cnt <= cnt - CNT_LAST;
               end
            end
            HOLD: begin
               ack_q <= 1'b1;
               state <= IDLE;
            end
            PULSE: begin
               if (cnt == CNT_LAST) begin
                  lset_q <= 1'b0;
                  lrst_q <= 1'b0;
                  done_q <= 1'b1;
                  state  <= RECOVER;
               end else begin
                  cnt <= cnt - CNT_LAST;
               end
            end
            RECOVER: begin
               ack_q <= 1'b1;
               state <= IDLE;
            end
            default: begin
               lge_q  <= 1'b0;
               lset_q <= 1'b0;
               lrst_q <= 1'b0;
               ack_q  <= 1'b1;
               state  <= IDLE;
            end
         endcase
      end
   end

   assign bus.ack  = ack_q;
   assign bus.li   = li_q;
   assign bus.lge  = lge_q;
   assign bus.lset = lset_q;
   assign bus.lrst = lrst_q;
   assign bus.done = done_q;
   assign bus.err  = err_q;
endmodule

// File: tb/tb_latch_gate_seq.sv
// Bench for latch_gate_seq: vector table, hand-written corner sequences, then a reference-model run.
module tb_latch_gate_seq;
   localparam int W = 8;
   localparam int G = 2;
   localparam int P = 3;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   latch_gate_seq_if #(.WIDTH(W)) bus();

   latch_gate_seq #(
      .WIDTH(W), .GATE_CYCLES(G), .PULSE_CYCLES(P)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int checks = 0;
   int errors = 0;

   typedef struct {
      string      name;
      logic [1:0] cmd;
      logic [7:0] d;
      logic [7:0] lge_m;
      logic [7:0] lset_m;
      logic [7:0] lrst_m;
      logic [7:0] done_m;
      logic [7:0] err_m;
      int         ack_k;
      logic [7:0] li;
   } vec_t;

   vec_t vecs[6];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Issues one command from idle and records 8 cycles of pins as bitmasks (bit k = cycle k).
   task automatic run_cmd(input logic [1:0] cmd, input logic [7:0] d,
                          output logic [7:0] lge_m, output logic [7:0] lset_m,
                          output logic [7:0] lrst_m, output logic [7:0] done_m,
                          output logic [7:0] err_m, output int ack_k,
                          output logic [7:0] li0, output logic [7:0] li_end,
                          output int viol);
      bus.req = 1'b1;
      bus.cmd = cmd;
      bus.d   = d;
      step();
      bus.req = 1'b0;
      bus.cmd = 2'b00;
      bus.d   = 8'h00;
      lge_m = '0; lset_m = '0; lrst_m = '0; done_m = '0; err_m = '0;
      ack_k = 99;
      viol  = 0;
      li0   = bus.li;
      for (int k = 0; k < 8; k++) begin
         lge_m[k]  = bus.lge;
         lset_m[k] = bus.lset;
         lrst_m[k] = bus.lrst;
         done_m[k] = bus.done;
         err_m[k]  = bus.err;
         if (bus.ack && ack_k == 99) ack_k = k;
         if ((bus.lset && bus.lrst) || (bus.lge && (bus.lset || bus.lrst))) viol++;
         if (k < 7) step();
      end
      li_end = bus.li;
   endtask

   logic [7:0] m_lge, m_lset, m_lrst, m_done, m_err, m_li0, m_li;
   int         m_ack, m_viol;

   // Reference model: activity described as "kind of command + cycles since accept".
   int         kind;
   int         k_since;
   logic       err_f;
   logic [7:0] ref_li;
   int         accepts;
   int         dut_dones;
   int         viol_cnt;

   function automatic logic [31:0] model_out();
      logic e_ack, e_lge, e_lset, e_lrst, e_done, e_err;
      e_ack  = (kind == 0);
      e_lge  = (kind == 1) && (k_since >= 1) && (k_since <= G);
      e_lrst = (kind == 2) && (k_since < P);
      e_lset = (kind == 3) && (k_since < P);
      e_done = ((kind == 1) && (k_since == G + 1)) || ((kind >= 2) && (k_since == P));
      e_err  = (kind == 0) && err_f;
      return 32'({e_ack, ref_li, e_lge, e_lset, e_lrst, e_done, e_err});
   endfunction

   initial begin
      vecs[0] = '{"write_a5",   2'b00, 8'hA5, 8'h06, 8'h00, 8'h00, 8'h08, 8'h00, 4, 8'hA5};
      vecs[1] = '{"clear",      2'b01, 8'h11, 8'h00, 8'h00, 8'h07, 8'h08, 8'h00, 4, 8'hA5};
      vecs[2] = '{"preset",     2'b10, 8'h22, 8'h00, 8'h07, 8'h00, 8'h08, 8'h00, 4, 8'hA5};
      vecs[3] = '{"illegal",    2'b11, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 0, 8'hA5};
      vecs[4] = '{"write_00",   2'b00, 8'h00, 8'h06, 8'h00, 8'h00, 8'h08, 8'h00, 4, 8'h00};
      vecs[5] = '{"write_c3",   2'b00, 8'hC3, 8'h06, 8'h00, 8'h00, 8'h08, 8'h00, 4, 8'hC3};

      bus.req = 1'b0;
      bus.cmd = 2'b00;
      bus.d   = 8'h00;

      // Reset held for 3 cycles, then released.
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_pins", 32'({bus.ack, bus.li, bus.lge, bus.lset, bus.lrst, bus.done, bus.err}),
          32'({1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0}));
      rst_n = 1'b1;
      step();
      chk("init_exit", 32'({bus.ack, bus.li, bus.lrst}), 32'({1'b1, 8'h00, 1'b0}));

      for (int i = 0; i < 6; i++) begin
         run_cmd(vecs[i].cmd, vecs[i].d, m_lge, m_lset, m_lrst, m_done, m_err,
                 m_ack, m_li0, m_li, m_viol);
         chk({vecs[i].name, "_lge"},  32'(m_lge),  32'(vecs[i].lge_m));
         chk({vecs[i].name, "_lset"}, 32'(m_lset), 32'(vecs[i].lset_m));
         chk({vecs[i].name, "_lrst"}, 32'(m_lrst), 32'(vecs[i].lrst_m));
         chk({vecs[i].name, "_done"}, 32'(m_done), 32'(vecs[i].done_m));
         chk({vecs[i].name, "_err"},  32'(m_err),  32'(vecs[i].err_m));
         chk({vecs[i].name, "_ack"},  32'(m_ack),  32'(vecs[i].ack_k));
         chk({vecs[i].name, "_li0"},  32'(m_li0),  32'(vecs[i].li));
         chk({vecs[i].name, "_li"},   32'(m_li),   32'(vecs[i].li));
         chk({vecs[i].name, "_excl"}, 32'(m_viol), 32'd0);
      end

      // Illegal command immediately followed by a write on the next edge.
      bus.req = 1'b1;
      bus.cmd = 2'b11;
      bus.d   = 8'h99;
      step();
      chk("ill_err", 32'({bus.err, bus.ack, bus.done, bus.li}), 32'({1'b1, 1'b1, 1'b0, 8'hC3}));
      bus.cmd = 2'b00;
      bus.d   = 8'h3C;
      step();
      bus.req = 1'b0;
      chk("b2b_accept", 32'({bus.li, bus.ack, bus.err, bus.done, bus.lge}),
          32'({8'h3C, 1'b0, 1'b0, 1'b0, 1'b0}));
      step();
      chk("b2b_gate", 32'(bus.lge), 32'd1);
      step();
      step();
      chk("b2b_done", 32'({bus.done, bus.lge, bus.ack}), 32'({1'b1, 1'b0, 1'b0}));
      step();
      chk("b2b_ack", 32'({bus.ack, bus.done}), 32'({1'b1, 1'b0}));

      // Reset while the gate is open.
      bus.req = 1'b1;
      bus.cmd = 2'b00;
      bus.d   = 8'h5A;
      step();
      bus.req = 1'b0;
      step();
      chk("rg_gate_open", 32'(bus.lge), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("rg_async", 32'({bus.ack, bus.li, bus.lge, bus.lset, bus.lrst, bus.done, bus.err}),
          32'({1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0}));
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("rg_no_done", 32'({bus.done, bus.lge}), 32'd0);
      end
      rst_n = 1'b1;
      step();
      chk("rg_reinit", 32'({bus.ack, bus.lrst}), 32'({1'b1, 1'b0}));
      run_cmd(2'b00, 8'h77, m_lge, m_lset, m_lrst, m_done, m_err, m_ack, m_li0, m_li, m_viol);
      chk("rg_wr_lge",  32'(m_lge),  32'h06);
      chk("rg_wr_done", 32'(m_done), 32'h08);
      chk("rg_wr_li",   32'(m_li),   32'h77);

      // Continuous REQ with writes, then random traffic, against the model.
      kind      = 0;
      k_since   = 0;
      err_f     = 1'b0;
      ref_li    = 8'h77;
      accepts   = 0;
      dut_dones = 0;
      viol_cnt  = 0;
      for (int n = 0; n < 1500; n++) begin
         chk("model_pins", 32'({bus.ack, bus.li, bus.lge, bus.lset, bus.lrst, bus.done, bus.err}),
             model_out());
         if (bus.done) dut_dones++;
         if ((bus.lset && bus.lrst) || (bus.lge && (bus.lset || bus.lrst))) viol_cnt++;
         if (n < 60) begin
            bus.req = 1'b1;
            bus.cmd = 2'b00;
            bus.d   = 8'(n) ^ 8'h5A;
         end else if (n < 1480) begin
            bus.req = ($urandom_range(0, 3) != 0);
            bus.cmd = 2'($urandom_range(0, 3));
            bus.d   = 8'($urandom);
         end else begin
            bus.req = 1'b0;
         end
         if (kind == 0) begin
            err_f = 1'b0;
            if (bus.req) begin
               k_since = 0;
               case (bus.cmd)
                  2'b00: begin kind = 1; ref_li = bus.d; accepts++; end
                  2'b01: begin kind = 2; accepts++; end
                  2'b10: begin kind = 3; accepts++; end
                  default: err_f = 1'b1;
               endcase
            end
         end else begin
            k_since++;
            if ((kind == 1 && k_since == G + 2) || (kind >= 2 && k_since == P + 1)) kind = 0;
         end
         @(negedge clk);
      end
      chk("done_per_accept", 32'(dut_dones), 32'(accepts));
      chk("pin_exclusion", 32'(viol_cnt), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
